// File: rtl/systolic_pe_cfg.sv
// Systolic-array processing element: double-buffered weight (shift-chain load + swap),
// valid-qualified wavefront, MAC / brightness-add / pass, optional signed and saturating accumulate.
module systolic_pe_cfg #(
  parameter int DATA_W   = 16,
  parameter int WT_W     = 16,
  parameter int ACC_W    = 40,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              wt_load,
  input  logic [WT_W-1:0]   wt_in,
  output logic [WT_W-1:0]   wt_out,
  input  logic              wt_swap,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ACC_W-1:0]  acc_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic              sat_flag
);

  localparam int PW = DATA_W + WT_W;
  localparam int EW = ACC_W + 2;

  if (WT_W < 1 || WT_W > DATA_W) begin : g_bad_wt_w
    $error("systolic_pe_cfg: WT_W must lie in 1..DATA_W");
  end
  if (ACC_W < DATA_W + WT_W) begin : g_bad_acc_w
    $error("systolic_pe_cfg: ACC_W must be >= DATA_W + WT_W");
  end

  localparam logic [1:0] MODE_MAC = 2'b00;
  localparam logic [1:0] MODE_ADD = 2'b01;

  logic [WT_W-1:0] shadow_wt;
  logic [WT_W-1:0] active_wt;

  assign wt_out = shadow_wt;

  // Swap samples the pre-edge shadow, so a same-cycle load+swap moves the old weight forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_wt <= '0;
      active_wt <= '0;
    end else begin
      if (wt_load) shadow_wt <= wt_in;
      if (wt_swap) active_wt <= shadow_wt;
    end
  end

  logic data_s, wt_s, acc_s, prod_s;
  logic [PW-1:0] data_p, wt_p, prod;
  logic [EW-1:0] data_x, wt_x, acc_x, prod_x;

  assign data_s = (SIGNED != 0) && data_in[DATA_W-1];
  assign wt_s   = (SIGNED != 0) && active_wt[WT_W-1];
  assign acc_s  = (SIGNED != 0) && acc_in[ACC_W-1];

  // The product is exact modulo 2^PW for both signednesses, so the multiplier stays PW wide.
  assign data_p = {{(PW-DATA_W){data_s}}, data_in};
  assign wt_p   = {{(PW-WT_W){wt_s}}, active_wt};
  assign prod   = data_p * wt_p;
  assign prod_s = (SIGNED != 0) && prod[PW-1];

  assign data_x = {{(EW-DATA_W){data_s}}, data_in};
  assign wt_x   = {{(EW-WT_W){wt_s}}, active_wt};
  assign acc_x  = {{(EW-ACC_W){acc_s}}, acc_in};
  assign prod_x = {{(EW-PW){prod_s}}, prod};

  logic [EW-1:0]    sum;
  logic             ovf;
  logic             pass_sel;
  logic [ACC_W-1:0] result;
  logic [ACC_W-1:0] max_s, min_s;

  assign max_s = {1'b0, {(ACC_W-1){1'b1}}};
  assign min_s = {1'b1, {(ACC_W-1){1'b0}}};

  always_comb begin
    sum      = acc_x;
    pass_sel = 1'b0;
    case (mode)
      MODE_MAC: sum = acc_x + prod_x;
      MODE_ADD: sum = acc_x + data_x + wt_x;
      default:  pass_sel = 1'b1;
    endcase
  end

  // Signed overflow: the guard bits above the result's sign bit are not a pure sign extension.
  always_comb begin
    ovf = 1'b0;
    if (!pass_sel) begin
      if (SIGNED != 0)
        ovf = !((&sum[EW-1:ACC_W-1]) || !(|sum[EW-1:ACC_W-1]));
      else
        ovf = |sum[EW-1:ACC_W];
    end
  end

  always_comb begin
    result = sum[ACC_W-1:0];
    if (ovf && (SATURATE != 0)) begin
      if (SIGNED != 0)
        result = sum[EW-1] ? min_s : max_s;
      else
        result = '1;
    end
  end

  // Bubbles only drop valid_out; the data path registers hold their last sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      acc_out   <= '0;
      sat_flag  <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        data_out <= data_in;
        acc_out  <= result;
        sat_flag <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe_cfg.sv
// Scoreboard bench for systolic_pe_cfg: default, signed, and small saturate/wrap instances.
module tb_systolic_pe_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (unsigned, 16/16/40, saturating)
  logic        a_reset = 1'b1, a_wt_load = 1'b0, a_wt_swap = 1'b0, a_valid_in = 1'b0;
  logic [1:0]  a_mode = 2'b00;
  logic [15:0] a_wt_in = '0, a_data_in = '0;
  logic [39:0] a_acc_in = '0;
  logic [15:0] a_wt_out, a_data_out;
  logic [39:0] a_acc_out;
  logic        a_valid_out, a_sat;

  // Instance B: signed, 16/16/40, saturating
  logic        b_reset = 1'b1, b_wt_load = 1'b0, b_wt_swap = 1'b0, b_valid_in = 1'b0;
  logic [1:0]  b_mode = 2'b00;
  logic [15:0] b_wt_in = '0, b_data_in = '0;
  logic [39:0] b_acc_in = '0;
  logic [15:0] b_wt_out, b_data_out;
  logic [39:0] b_acc_out;
  logic        b_valid_out, b_sat;

  // Instances C2 (saturate) and C3 (wrap): unsigned 8/8/20, shared stimulus
  logic        c_reset = 1'b1, c_wt_load = 1'b0, c_wt_swap = 1'b0, c_valid_in = 1'b0;
  logic [1:0]  c_mode = 2'b00;
  logic [7:0]  c_wt_in = '0, c_data_in = '0;
  logic [19:0] c_acc_in = '0;
  logic [7:0]  c2_wt_out, c2_data_out, c3_wt_out, c3_data_out;
  logic [19:0] c2_acc_out, c3_acc_out;
  logic        c2_valid_out, c2_sat, c3_valid_out, c3_sat;

  systolic_pe_cfg dut_a (
    .clk(clk), .reset(a_reset), .mode(a_mode), .wt_load(a_wt_load), .wt_in(a_wt_in),
    .wt_out(a_wt_out), .wt_swap(a_wt_swap), .valid_in(a_valid_in), .data_in(a_data_in),
    .acc_in(a_acc_in), .valid_out(a_valid_out), .data_out(a_data_out), .acc_out(a_acc_out),
    .sat_flag(a_sat));

  systolic_pe_cfg #(.SIGNED(1)) dut_b (
    .clk(clk), .reset(b_reset), .mode(b_mode), .wt_load(b_wt_load), .wt_in(b_wt_in),
    .wt_out(b_wt_out), .wt_swap(b_wt_swap), .valid_in(b_valid_in), .data_in(b_data_in),
    .acc_in(b_acc_in), .valid_out(b_valid_out), .data_out(b_data_out), .acc_out(b_acc_out),
    .sat_flag(b_sat));

  systolic_pe_cfg #(.DATA_W(8), .WT_W(8), .ACC_W(20), .SIGNED(0), .SATURATE(1)) dut_c2 (
    .clk(clk), .reset(c_reset), .mode(c_mode), .wt_load(c_wt_load), .wt_in(c_wt_in),
    .wt_out(c2_wt_out), .wt_swap(c_wt_swap), .valid_in(c_valid_in), .data_in(c_data_in),
    .acc_in(c_acc_in), .valid_out(c2_valid_out), .data_out(c2_data_out), .acc_out(c2_acc_out),
    .sat_flag(c2_sat));

  systolic_pe_cfg #(.DATA_W(8), .WT_W(8), .ACC_W(20), .SIGNED(0), .SATURATE(0)) dut_c3 (
    .clk(clk), .reset(c_reset), .mode(c_mode), .wt_load(c_wt_load), .wt_in(c_wt_in),
    .wt_out(c3_wt_out), .wt_swap(c_wt_swap), .valid_in(c_valid_in), .data_in(c_data_in),
    .acc_in(c_acc_in), .valid_out(c3_valid_out), .data_out(c3_data_out), .acc_out(c3_acc_out),
    .sat_flag(c3_sat));

  typedef struct {
    logic [39:0] acc;
    logic [15:0] data;
    logic        sat;
  } exp_t;

  exp_t qa[$], qb[$], q2[$], q3[$];
  exp_t ea, eb, e2, e3;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic exp_t mk(logic [39:0] acc, logic [15:0] data, logic sat);
    exp_t e;
    e.acc = acc; e.data = data; e.sat = sat;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: valid_out=1 with no expected sample queued at %0t", name, $time);
  endtask

  // Monitor: pops one expectation per presented sample.
  always @(negedge clk) begin
    if (a_valid_out) begin
      if (qa.size() == 0) unexpected("a_out");
      else begin
        ea = qa.pop_front();
        chk("a_acc", a_acc_out, ea.acc); chk("a_data", a_data_out, ea.data); chk("a_sat", a_sat, ea.sat);
      end
    end
    if (b_valid_out) begin
      if (qb.size() == 0) unexpected("b_out");
      else begin
        eb = qb.pop_front();
        chk("b_acc", b_acc_out, eb.acc); chk("b_data", b_data_out, eb.data); chk("b_sat", b_sat, eb.sat);
      end
    end
    if (c2_valid_out) begin
      if (q2.size() == 0) unexpected("c2_out");
      else begin
        e2 = q2.pop_front();
        chk("c2_acc", c2_acc_out, e2.acc); chk("c2_data", c2_data_out, e2.data); chk("c2_sat", c2_sat, e2.sat);
      end
    end
    if (c3_valid_out) begin
      if (q3.size() == 0) unexpected("c3_out");
      else begin
        e3 = q3.pop_front();
        chk("c3_acc", c3_acc_out, e3.acc); chk("c3_data", c3_data_out, e3.data); chk("c3_sat", c3_sat, e3.sat);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_sample(input logic [1:0] m, input logic [15:0] d, input logic [39:0] acc,
                          input logic [39:0] exp_acc, input logic exp_sat);
    a_mode = m; a_data_in = d; a_acc_in = acc; a_valid_in = 1'b1;
    qa.push_back(mk(exp_acc, d, exp_sat));
  endtask

  task automatic b_sample(input logic [1:0] m, input logic [15:0] d, input logic [39:0] acc,
                          input logic [39:0] exp_acc, input logic exp_sat);
    b_mode = m; b_data_in = d; b_acc_in = acc; b_valid_in = 1'b1;
    qb.push_back(mk(exp_acc, d, exp_sat));
  endtask

  task automatic c_sample(input logic [1:0] m, input logic [7:0] d, input logic [19:0] acc,
                          input logic [19:0] exp2, input logic [19:0] exp3, input logic exp_sat);
    c_mode = m; c_data_in = d; c_acc_in = acc; c_valid_in = 1'b1;
    q2.push_back(mk({20'd0, exp2}, {8'd0, d}, exp_sat));
    q3.push_back(mk({20'd0, exp3}, {8'd0, d}, exp_sat));
  endtask

  task automatic a_check_idle(input string tag, input logic [15:0] wt, input logic [15:0] d,
                              input logic [39:0] acc, input logic sat);
    chk({tag, "_wt_out"}, a_wt_out, wt);
    chk({tag, "_valid"}, a_valid_out, 1'b0);
    chk({tag, "_data"}, a_data_out, d);
    chk({tag, "_acc"}, a_acc_out, acc);
    chk({tag, "_sat"}, a_sat, sat);
  endtask

  initial begin
    // Reset with random activity on every input of A
    a_valid_in = 1'b1; a_wt_load = 1'b1; a_wt_swap = 1'b1;
    a_mode = 2'($urandom); a_wt_in = 16'($urandom); a_data_in = 16'($urandom);
    a_acc_in = {8'($urandom), 32'($urandom)};
    step(); step();
    a_check_idle("rst", 16'd0, 16'd0, 40'd0, 1'b0);
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
    a_valid_in = 1'b0; a_wt_load = 1'b0; a_wt_swap = 1'b0;
    step();
    a_check_idle("post_rst", 16'd0, 16'd0, 40'd0, 1'b0);

    // Load / swap
    a_wt_load = 1'b1; a_wt_in = 16'd3;
    step();
    a_wt_load = 1'b0;
    chk("load_wt_out", a_wt_out, 16'd3);
    a_sample(2'b00, 16'd5, 40'd10, 40'd10, 1'b0);
    step();
    a_valid_in = 1'b0; a_wt_swap = 1'b1;
    step();
    a_wt_swap = 1'b0;
    chk("hold_wt_out", a_wt_out, 16'd3);
    a_sample(2'b00, 16'd5, 40'd10, 40'd25, 1'b0);
    step();
    a_valid_in = 1'b0;

    // Simultaneous load + swap with compute in the same cycle
    a_reset = 1'b1;
    step();
    a_reset = 1'b0;
    chk("rst2_wt_out", a_wt_out, 16'd0);
    a_wt_load = 1'b1; a_wt_in = 16'd3;
    step();
    a_wt_in = 16'd7; a_wt_swap = 1'b1;
    a_sample(2'b00, 16'd2, 40'd0, 40'd0, 1'b0);
    step();
    a_wt_load = 1'b0; a_wt_swap = 1'b0;
    chk("simul_wt_out", a_wt_out, 16'd7);
    a_sample(2'b00, 16'd2, 40'd0, 40'd6, 1'b0);
    step();

    // ADD then bubbles: outputs must hold while inputs change
    a_sample(2'b01, 16'd9, 40'd1, 40'd13, 1'b0);
    step();
    a_valid_in = 1'b0; a_data_in = 16'd77; a_acc_in = 40'd99; a_mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      a_check_idle("bubble", 16'd7, 16'd9, 40'd13, 1'b0);
    end

    // Reserved / pass modes, then unsigned saturation and flag clearing
    a_sample(2'b11, 16'd4, 40'd42, 40'd42, 1'b0);
    step();
    a_sample(2'b10, 16'd1, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b0);
    step();
    a_sample(2'b00, 16'd1, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1);
    step();
    a_sample(2'b00, 16'd1, 40'd0, 40'd3, 1'b0);
    step();
    a_valid_in = 1'b0;

    // Signed instance: weight -20
    b_wt_load = 1'b1; b_wt_in = 16'hFFEC;
    step();
    b_wt_load = 1'b0; b_wt_swap = 1'b1;
    step();
    b_wt_swap = 1'b0;
    chk("b_wt_out", b_wt_out, 16'hFFEC);
    b_sample(2'b01, 16'd100, 40'd0, 40'd80, 1'b0);
    step();
    b_sample(2'b00, 16'hFFFD, 40'd5, 40'd65, 1'b0);
    step();
    b_sample(2'b00, 16'hFFFF, 40'h7F_FFFF_FFFF, 40'h7F_FFFF_FFFF, 1'b1);
    step();
    b_sample(2'b00, 16'h0001, 40'h80_0000_0000, 40'h80_0000_0000, 1'b1);
    step();
    b_sample(2'b00, 16'h0001, 40'h80_0000_0014, 40'h80_0000_0000, 1'b0);
    step();
    b_sample(2'b01, 16'h8000, 40'd0, 40'hFF_FFFF_7FEC, 1'b0);
    step();
    b_valid_in = 1'b0;

    // Small unsigned instances: saturate vs wrap
    c_wt_load = 1'b1; c_wt_in = 8'hFF;
    step();
    c_wt_load = 1'b0; c_wt_swap = 1'b1;
    step();
    c_wt_swap = 1'b0;
    c_sample(2'b00, 8'hFF, 20'd1048000, 20'd1048575, 20'd64449, 1'b1);
    step();
    c_sample(2'b00, 8'hFF, 20'd983550, 20'd1048575, 20'd1048575, 1'b0);
    step();
    c_sample(2'b01, 8'h00, 20'hFFFFF, 20'hFFFFF, 20'h000FE, 1'b1);
    step();
    c_valid_in = 1'b0;

    step(); step();
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    chk("q3_drained", 64'(q3.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
